sum_accum: RTL and testbench

Downstream stage of the 4-bit adder: takes its registered 5-bit sum as a stream of samples and accumulates a fixed-size window of them into one wider total. Upstream offers samples with a valid/ready handshake. Each completed total is presented downstream with a second valid/ready handshake and held until it is taken. The block sits between the adder's Sum output and any consumer of windowed totals.

---
 rtl/sum_accum_pkg.sv | 15 +
 rtl/sum_accum_add.sv | 36 +++
 rtl/sum_accum.sv | 143 ++++++++++++++
 tb/tb_sum_accum.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_accum_pkg.sv
// sum_accum_pkg: shared state encoding and default sizing for the windowed
// sample accumulator (sum_accum and its adder sub-block).
package sum_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int IN_W_DEF        = 5;
    localparam int NUM_SAMPLES_DEF = 4;
    localparam int ACC_W_DEF       = 7;

endpackage

// File: rtl/sum_accum_add.sv
// sum_accum_add: combinational accumulator adder. Adds the zero-extended
// sample to the running total and reports carry-out of the ACC_W-bit sum.
// Build option SUM_ACCUM_SAT_EN: when defined, a carry-out clamps the result
// to all-ones; when undefined, the result wraps modulo 2^ACC_W.
module sum_accum_add
    import sum_accum_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [IN_W-1:0]  sample,
    output logic [ACC_W-1:0] acc_next,
    output logic             carry
);

    logic [ACC_W:0] sum_s;

    // Full-width add with one spare bit to expose the carry, then wrap or clamp.
    always_comb begin
        sum_s = {1'b0, acc} + {1'b0, ACC_W'(sample)};
        carry = sum_s[ACC_W];
`ifdef SUM_ACCUM_SAT_EN
        // Once clamped, acc is all-ones, so any further non-zero sample carries
        // again and the total stays pinned for the rest of the window.
        if (carry) begin
            acc_next = {ACC_W{1'b1}};
        end else begin
            acc_next = sum_s[ACC_W-1:0];
        end
`else
        acc_next = sum_s[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/sum_accum.sv
// sum_accum: accumulates NUM_SAMPLES handshaked samples into one ACC_W-bit
// total, then holds the total on a valid/ready output until taken.
// Build option SUM_ACCUM_SAT_EN selects saturating (defined) or wrapping
// (undefined) accumulation; out_ovf reports carry-out in both builds.
// rst is asynchronous active-low; flush is a synchronous window abort.
module sum_accum
    import sum_accum_pkg::*;
#(
    parameter int IN_W        = IN_W_DEF,
    parameter int NUM_SAMPLES = NUM_SAMPLES_DEF,
    parameter int ACC_W       = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [IN_W-1:0]  in_sum,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_total,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_ovf,
    output logic             busy
);

    localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
    // cnt holds the number of samples already in acc; the sample accepted
    // while cnt equals this value completes the window.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic             accept_s;
    logic [ACC_W-1:0] sample_ext_s;
    logic [ACC_W-1:0] add_next_s;
    logic             add_carry_s;

    sum_accum_add #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_add (
        .acc      (acc_q),
        .sample   (in_sum),
        .acc_next (add_next_s),
        .carry    (add_carry_s)
    );

    // Handshake decode: ready depends only on state, never on out_ready.
    always_comb begin
        in_ready     = (state_q != HOLD);
        accept_s     = in_valid && in_ready;
        sample_ext_s = ACC_W'(in_sum);
    end

    // Next-state, accumulator, counter and overflow update; flush overrides all.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (flush) begin
            state_d = IDLE;
            acc_d   = {ACC_W{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        acc_d = sample_ext_s;
                        cnt_d = CNT_W'(1);
                        ovf_d = 1'b0;
                        if (NUM_SAMPLES == 1) begin
                            state_d = HOLD;
                        end else begin
                            state_d = ACCUM;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                ACCUM: begin
                    if (accept_s) begin
                        acc_d = add_next_s;
                        cnt_d = cnt_q + CNT_W'(1);
                        ovf_d = ovf_q | add_carry_s;
                        if (cnt_q == LAST_CNT) begin
                            state_d = HOLD;
                        end else begin
                            state_d = ACCUM;
                        end
                    end else begin
                        state_d = ACCUM;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = {ACC_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    ovf_d   = 1'b0;
                end
            endcase
        end
        out_valid_d = (state_d == HOLD);
    end

    // State and datapath registers, cleared asynchronously by rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            acc_q       <= {ACC_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Outputs come straight from registers (busy is a state decode).
    always_comb begin
        out_total = acc_q;
        out_ovf   = ovf_q;
        out_valid = out_valid_q;
        busy      = (state_q == ACCUM);
    end

endmodule

// File: tb/tb_sum_accum.sv
// tb_sum_accum: directed self-checking bench for sum_accum (default sizing)
// plus a second ACC_W=6 instance for the overflow case. Expected overflow
// total follows the SUM_ACCUM_SAT_EN build option.
module tb_sum_accum;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [4:0] in_sum;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] out_total;
    logic       out_valid;
    logic       out_ready;
    logic       out_ovf;
    logic       busy;

    logic [4:0] in_sum6;
    logic       in_valid6;
    logic       in_ready6;
    logic [5:0] out_total6;
    logic       out_valid6;
    logic       out_ready6;
    logic       out_ovf6;
    logic       busy6;

    int tests_run;
    int tests_failed;

    sum_accum dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_sum    (in_sum),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_total (out_total),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    sum_accum #(.IN_W(5), .NUM_SAMPLES(4), .ACC_W(6)) dut6 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_sum    (in_sum6),
        .in_valid  (in_valid6),
        .in_ready  (in_ready6),
        .out_total (out_total6),
        .out_valid (out_valid6),
        .out_ready (out_ready6),
        .out_ovf   (out_ovf6),
        .busy      (busy6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare every output against its reset value.
    task automatic check_reset_outputs(input string tag);
        tests_run++;
        if (out_total !== 7'd0 || out_valid !== 1'b0 || out_ovf !== 1'b0 ||
            busy !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s: total=%0d valid=%b ovf=%b busy=%b ready=%b, required 0 0 0 0 1",
                     tag, out_total, out_valid, out_ovf, busy, in_ready);
        end
    endtask

    task automatic test_reset();
        check_reset_outputs("reset_values");
    endtask

    task automatic test_basic();
        logic [4:0] s [4] = '{5'd3, 5'd7, 5'd30, 5'd1};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_sum = s[i];
            step();
            if (i < 3) begin
                tests_run++;
                if (busy !== 1'b1 || out_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL basic_busy[%0d]: busy=%b valid=%b, required 1 0", i, busy, out_valid);
                end
            end
        end
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_total !== 7'd41 || out_ovf !== 1'b0 ||
            in_ready !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_hold: valid=%b total=%0d ovf=%b ready=%b busy=%b, required 1 41 0 0 0",
                     out_valid, out_total, out_ovf, in_ready, busy);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_one_cycle: valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sum    = 5'd31;
        for (int i = 0; i < 4; i++) step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_total !== 7'd124 || in_ready !== 1'b0 || out_ovf !== 1'b0) begin
                tests_failed++;
                $display("FAIL backpressure_hold[%0d]: valid=%b total=%0d ready=%b ovf=%b, required 1 124 0 0",
                         i, out_valid, out_total, in_ready, out_ovf);
            end
            step();
        end
        // Release, offering a sample in the handoff cycle: it must be refused.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sum    = 5'd5;
        tests_run++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL backpressure_release_cycle: valid=%b ready=%b, required 1 0", out_valid, in_ready);
        end
        step();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL backpressure_no_bypass: valid=%b busy=%b ready=%b, required 0 0 1",
                     out_valid, busy, in_ready);
        end
    endtask

    task automatic test_overflow();
        logic [4:0] s [4] = '{5'd31, 5'd31, 5'd31, 5'd1};
        logic [5:0] exp_total;
`ifdef SUM_ACCUM_SAT_EN
        exp_total = 6'd63;
`else
        exp_total = 6'd30;
`endif
        out_ready6 = 1'b1;
        in_valid6  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_sum6 = s[i];
            step();
        end
        in_valid6 = 1'b0;
        tests_run++;
        if (out_valid6 !== 1'b1 || out_total6 !== exp_total || out_ovf6 !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_acc6: valid=%b total=%0d ovf=%b, required 1 %0d 1",
                     out_valid6, out_total6, out_ovf6, exp_total);
        end
        step();
    endtask

    task automatic test_gapped();
        logic       v [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [4:0] s [7] = '{5'd2, 5'd0, 5'd0, 5'd4, 5'd6, 5'd0, 5'd8};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = v[i];
            in_sum   = s[i];
            step();
            if (i < 6) begin
                tests_run++;
                if (busy !== 1'b1 || out_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL gapped_busy[%0d]: busy=%b valid=%b, required 1 0", i, busy, out_valid);
                end
            end
        end
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_total !== 7'd20 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL gapped_total: valid=%b total=%0d busy=%b, required 1 20 0",
                     out_valid, out_total, busy);
        end
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sum    = 5'd1;
        step();
        step();
        flush  = 1'b1;
        in_sum = 5'd9;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_total !== 7'd0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_idle: busy=%b valid=%b total=%0d ready=%b, required 0 0 0 1",
                     busy, out_valid, out_total, in_ready);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_no_output: valid=%b busy=%b, required 0 0", out_valid, busy);
        end
        in_valid = 1'b1;
        in_sum   = 5'd1;
        for (int i = 0; i < 4; i++) step();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_total !== 7'd4 || out_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_next_window: valid=%b total=%0d ovf=%b, required 1 4 0",
                     out_valid, out_total, out_ovf);
        end
        step();
    endtask

    task automatic test_async_reset();
        // Mid-window reset.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sum    = 5'd10;
        step();
        step();
        in_valid = 1'b0;
        #1 rst = 1'b0;
        #1 check_reset_outputs("reset_mid_window");
        #1 rst = 1'b1;
        in_valid = 1'b1;
        in_sum   = 5'd2;
        for (int i = 0; i < 4; i++) step();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_total !== 7'd8) begin
            tests_failed++;
            $display("FAIL reset_window_after_mid: valid=%b total=%0d, required 1 8", out_valid, out_total);
        end
        step();
        // Reset while holding an untaken total.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sum    = 5'd5;
        for (int i = 0; i < 4; i++) step();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_total !== 7'd20) begin
            tests_failed++;
            $display("FAIL reset_prehold: valid=%b total=%0d, required 1 20", out_valid, out_total);
        end
        #1 rst = 1'b0;
        #1 check_reset_outputs("reset_in_hold");
        #1 rst = 1'b1;
        out_ready = 1'b1;
        step();
        check_reset_outputs("reset_no_stale_total");
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_sum = 5'(i);
            step();
        end
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_total !== 7'd10 || out_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_window_after_hold: valid=%b total=%0d ovf=%b, required 1 10 0",
                     out_valid, out_total, out_ovf);
        end
        step();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        flush        = 1'b0;
        in_sum       = 5'd0;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        in_sum6      = 5'd0;
        in_valid6    = 1'b0;
        out_ready6   = 1'b1;
        #3;
        test_reset();
        #4 rst = 1'b1;
        step();
        test_basic();
        test_backpressure();
        test_overflow();
        test_gapped();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
